ahb_decoder_dp: RTL and testbench



---
 rtl/ahb_decoder_dp.sv | 117 +++++++++++
 tb/tb_ahb_decoder_dp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_decoder_dp.sv
// AHB address decoder with registered data-phase select and a built-in default slave
// that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR response.
module ahb_decoder_dp #(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int SLAVE_NUM      = 4,
   parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] LOW_ADDR  =
      {32'h0000_5000, 32'h0000_2400, 32'h0000_0400, 32'h0000_0000},
   parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] HIGH_ADDR =
      {32'h0000_5FFF, 32'h0000_24FF, 32'h0000_0CFF, 32'h0000_03FF},
   parameter logic [AHB_ADDR_WIDTH-1:0] REMAP_LOW  = 32'h0000_0000,
   parameter logic [AHB_ADDR_WIDTH-1:0] REMAP_HIGH = 32'h0000_03FF,
   parameter int REMAP_SLAVE = 1,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                      hclk,
   input  logic                      hreset_n,
   input  logic [AHB_ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]                htrans,
   input  logic                      hready,
   input  logic                      hremap,
   output logic [SLAVE_NUM-1:0]      hsel,
   output logic                      default_slv_sel,
   output logic [SLAVE_NUM-1:0]      data_sel,
   output logic                      data_def_sel,
   output logic                      hreadyout_def,
   output logic                      hresp_def,
   output logic [ERR_CNT_W-1:0]      err_cnt
);

   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [SLAVE_NUM-1:0] REMAP_ONEHOT = SLAVE_NUM'(1) << REMAP_SLAVE;

   typedef enum logic [1:0] {
      ST_OK   = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } def_state_t;

   def_state_t               state;
   logic [SLAVE_NUM-1:0]     prio_sel;
   logic [SLAVE_NUM-1:0]     dec_sel;
   logic                     remap_hit;
   logic                     trans_active;
   logic                     err_start;

   // Bounds are passed as arguments so a zero lower bound is not folded into a constant compare.
   function automatic logic in_range(input logic [AHB_ADDR_WIDTH-1:0] addr,
                                     input logic [AHB_ADDR_WIDTH-1:0] lo,
                                     input logic [AHB_ADDR_WIDTH-1:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

   // Scanning from the top index down lets the lowest matching region overwrite the rest.
   always_comb begin
      prio_sel = '0;
      for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
         if (in_range(haddr, LOW_ADDR[i], HIGH_ADDR[i])) begin
            prio_sel    = '0;
            prio_sel[i] = 1'b1;
         end
      end
      remap_hit = hremap && in_range(haddr, REMAP_LOW, REMAP_HIGH);
      dec_sel   = remap_hit ? REMAP_ONEHOT : prio_sel;
   end

   assign trans_active    = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   assign hsel            = trans_active ? dec_sel : '0;
   assign default_slv_sel = trans_active && (dec_sel == '0);
   assign err_start       = hready && default_slv_sel;

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         data_sel     <= '0;
         data_def_sel <= 1'b0;
      end else if (hready) begin
         data_sel     <= hsel;
         data_def_sel <= default_slv_sel;
      end
   end

   // Outputs are loaded together with the state they belong to, so they stay pure Moore.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state         <= ST_OK;
         hreadyout_def <= 1'b1;
         hresp_def     <= 1'b0;
         err_cnt       <= '0;
      end else begin
         case (state)
            ST_OK, ST_ERR2: begin
               if (err_start) begin
                  state         <= ST_ERR1;
                  hreadyout_def <= 1'b0;
                  hresp_def     <= 1'b1;
                  if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
               end else begin
                  state         <= ST_OK;
                  hreadyout_def <= 1'b1;
                  hresp_def     <= 1'b0;
               end
            end
            ST_ERR1: begin
               state         <= ST_ERR2;
               hreadyout_def <= 1'b1;
               hresp_def     <= 1'b1;
            end
            default: begin
               state         <= ST_OK;
               hreadyout_def <= 1'b1;
               hresp_def     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_decoder_dp.sv
// Directed bench for ahb_decoder_dp: a decode vector table plus hand-built error,
// stall, saturation and asynchronous reset sequences.
module tb_ahb_decoder_dp;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   logic        hclk;
   logic        hreset_n;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hready;
   logic        hremap;
   logic [3:0]  hsel;
   logic        default_slv_sel;
   logic [3:0]  data_sel;
   logic        data_def_sel;
   logic        hreadyout_def;
   logic        hresp_def;
   logic [7:0]  err_cnt;

   int checks;
   int failures;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        remap;
      logic [3:0]  exp_hsel;
      logic        exp_def;
   } vec_t;

   vec_t vecs[20];

   ahb_decoder_dp dut (
      .hclk            (hclk),
      .hreset_n        (hreset_n),
      .haddr           (haddr),
      .htrans          (htrans),
      .hready          (hready),
      .hremap          (hremap),
      .hsel            (hsel),
      .default_slv_sel (default_slv_sel),
      .data_sel        (data_sel),
      .data_def_sel    (data_def_sel),
      .hreadyout_def   (hreadyout_def),
      .hresp_def       (hresp_def),
      .err_cnt         (err_cnt)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired before the test finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Inputs change just after the falling edge, so combinational outputs settle before the next rising edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                                input logic ready, input logic remap);
      @(negedge hclk);
      haddr  = addr;
      htrans = trans;
      hready = ready;
      hremap = remap;
      #1;
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic doReset();
      @(negedge hclk);
      hreset_n = 1'b0;
      haddr    = '0;
      htrans   = IDLE;
      hready   = 1'b1;
      hremap   = 1'b0;
      @(negedge hclk);
      hreset_n = 1'b1;
   endtask

   task automatic checkFsm(input string name, input logic exp_ready, input logic exp_resp, input int exp_cnt);
      checkOutput({name, " hreadyout_def"}, 32'(hreadyout_def), 32'(exp_ready));
      checkOutput({name, " hresp_def"}, 32'(hresp_def), 32'(exp_resp));
      checkOutput({name, " err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      hreset_n = 1'b1;
      haddr    = '0;
      htrans   = IDLE;
      hready   = 1'b1;
      hremap   = 1'b0;

      vecs[0]  = '{32'h0000_03FF, NONSEQ, 1'b0, 4'b0001, 1'b0};
      vecs[1]  = '{32'h0000_0400, NONSEQ, 1'b0, 4'b0010, 1'b0};
      vecs[2]  = '{32'h0000_0CFF, SEQ,    1'b0, 4'b0010, 1'b0};
      vecs[3]  = '{32'h0000_0D00, NONSEQ, 1'b0, 4'b0000, 1'b1};
      vecs[4]  = '{32'h0000_23FF, NONSEQ, 1'b0, 4'b0000, 1'b1};
      vecs[5]  = '{32'h0000_2400, SEQ,    1'b0, 4'b0100, 1'b0};
      vecs[6]  = '{32'h0000_24FF, NONSEQ, 1'b0, 4'b0100, 1'b0};
      vecs[7]  = '{32'h0000_2500, NONSEQ, 1'b0, 4'b0000, 1'b1};
      vecs[8]  = '{32'h0000_5000, NONSEQ, 1'b0, 4'b1000, 1'b0};
      vecs[9]  = '{32'h0000_5FFF, SEQ,    1'b0, 4'b1000, 1'b0};
      vecs[10] = '{32'h0000_6000, NONSEQ, 1'b0, 4'b0000, 1'b1};
      vecs[11] = '{32'h0000_0010, NONSEQ, 1'b1, 4'b0010, 1'b0};
      vecs[12] = '{32'h0000_0010, NONSEQ, 1'b0, 4'b0001, 1'b0};
      vecs[13] = '{32'h0000_03FF, NONSEQ, 1'b1, 4'b0010, 1'b0};
      vecs[14] = '{32'h0000_0400, SEQ,    1'b1, 4'b0010, 1'b0};
      vecs[15] = '{32'h0000_1000, IDLE,   1'b0, 4'b0000, 1'b0};
      vecs[16] = '{32'h0000_5000, BUSY,   1'b0, 4'b0000, 1'b0};
      vecs[17] = '{32'h0000_1000, NONSEQ, 1'b1, 4'b0000, 1'b1};
      vecs[18] = '{32'hFFFF_FFFF, SEQ,    1'b0, 4'b0000, 1'b1};
      vecs[19] = '{32'h0000_0000, IDLE,   1'b1, 4'b0000, 1'b0};

      // Reset state, asserted asynchronously between clock edges.
      #2;
      hreset_n = 1'b0;
      #1;
      checkOutput("reset data_sel", 32'(data_sel), 32'h0);
      checkOutput("reset data_def_sel", 32'(data_def_sel), 32'h0);
      checkFsm("reset", 1'b1, 1'b0, 0);
      @(negedge hclk);
      hreset_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].addr, vecs[i].trans, 1'b1, vecs[i].remap);
         checkOutput($sformatf("vec%0d hsel", i), 32'(hsel), 32'(vecs[i].exp_hsel));
         checkOutput($sformatf("vec%0d default_slv_sel", i), 32'(default_slv_sel), 32'(vecs[i].exp_def));
         tick();
         checkOutput($sformatf("vec%0d data_sel", i), 32'(data_sel), 32'(vecs[i].exp_hsel));
         checkOutput($sformatf("vec%0d data_def_sel", i), 32'(data_def_sel), 32'(vecs[i].exp_def));
      end

      // Single error response: ERR1 then ERR2 then back to OK.
      doReset();
      applyStimulus(32'h0000_1000, NONSEQ, 1'b1, 1'b0);
      checkOutput("err default_slv_sel", 32'(default_slv_sel), 32'h1);
      tick();
      checkFsm("err ERR1", 1'b0, 1'b1, 1);
      applyStimulus(32'h0000_0000, IDLE, 1'b0, 1'b0);
      tick();
      checkFsm("err ERR2", 1'b1, 1'b1, 1);
      applyStimulus(32'h0000_1000, IDLE, 1'b1, 1'b0);
      tick();
      checkFsm("err back OK", 1'b1, 1'b0, 1);
      checkOutput("idle unmapped data_def_sel", 32'(data_def_sel), 32'h0);
      applyStimulus(32'h0000_7000, BUSY, 1'b1, 1'b0);
      tick();
      checkFsm("busy unmapped stays OK", 1'b1, 1'b0, 1);

      // Back-to-back errors, the second accepted while in ERR2.
      doReset();
      applyStimulus(32'h0000_1000, NONSEQ, 1'b1, 1'b0);
      tick();
      checkFsm("b2b ERR1 a", 1'b0, 1'b1, 1);
      applyStimulus(32'h0000_2000, NONSEQ, 1'b0, 1'b0);
      tick();
      checkFsm("b2b ERR2 a", 1'b1, 1'b1, 1);
      applyStimulus(32'h0000_2000, NONSEQ, 1'b1, 1'b0);
      tick();
      checkFsm("b2b ERR1 b", 1'b0, 1'b1, 2);
      applyStimulus(32'h0000_0000, IDLE, 1'b0, 1'b0);
      tick();
      checkFsm("b2b ERR2 b", 1'b1, 1'b1, 2);
      applyStimulus(32'h0000_0000, IDLE, 1'b1, 1'b0);
      tick();
      checkFsm("b2b OK", 1'b1, 1'b0, 2);

      // Stalled bus: address changes must not reach data_sel or the FSM.
      doReset();
      applyStimulus(32'h0000_0400, NONSEQ, 1'b1, 1'b0);
      tick();
      checkOutput("stall preload data_sel", 32'(data_sel), 32'h2);
      applyStimulus(32'h0000_5000, NONSEQ, 1'b0, 1'b0);
      tick();
      checkOutput("stall1 data_sel", 32'(data_sel), 32'h2);
      applyStimulus(32'h0000_1000, NONSEQ, 1'b0, 1'b0);
      tick();
      checkOutput("stall2 data_sel", 32'(data_sel), 32'h2);
      checkOutput("stall2 data_def_sel", 32'(data_def_sel), 32'h0);
      checkFsm("stall2", 1'b1, 1'b0, 0);
      applyStimulus(32'h0000_2400, SEQ, 1'b0, 1'b0);
      tick();
      checkOutput("stall3 data_sel", 32'(data_sel), 32'h2);

      // 300 error entries; the counter must stop at 255.
      doReset();
      for (int i = 0; i < 300; i++) begin
         applyStimulus(32'h0000_1000, NONSEQ, 1'b1, 1'b0);
         tick();
         applyStimulus(32'h0000_1000, NONSEQ, 1'b0, 1'b0);
         tick();
         if (i == 253) checkOutput("sat 254 entries", 32'(err_cnt), 32'd254);
      end
      checkOutput("sat 300 entries", 32'(err_cnt), 32'd255);
      applyStimulus(32'h0000_1000, NONSEQ, 1'b1, 1'b0);
      tick();
      checkFsm("sat held", 1'b0, 1'b1, 255);

      // Reset pulse in the middle of ERR1, then a normal first edge after release.
      doReset();
      applyStimulus(32'h0000_1000, NONSEQ, 1'b1, 1'b0);
      tick();
      checkFsm("abort ERR1", 1'b0, 1'b1, 1);
      @(negedge hclk);
      #2;
      hreset_n = 1'b0;
      #1;
      checkFsm("abort async", 1'b1, 1'b0, 0);
      checkOutput("abort data_def_sel", 32'(data_def_sel), 32'h0);
      haddr  = 32'h0000_1000;
      htrans = NONSEQ;
      hready = 1'b1;
      tick();
      checkFsm("abort held", 1'b1, 1'b0, 0);
      @(negedge hclk);
      hreset_n = 1'b1;
      #1;
      tick();
      checkFsm("first edge after reset", 1'b0, 1'b1, 1);
      checkOutput("first edge data_def_sel", 32'(data_def_sel), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
